sel_sequencer: RTL and testbench
================================

SEL_SEQUENCER -- requirements
Module: sel_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clock cycles per select step (dwell); legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, a request to begin a sequence, sampled when idle.
REQ-005 SHALL have port stop, input, 1, a request to abort a running sequence.
REQ-006 SHALL have port mode, input, 2: 00 single sweep up, 01 single sweep down, 10 continuous up, 11 continuous down; latched on accepted start.
REQ-007 SHALL have port load, input, 1, a request to preset the select value when idle.
REQ-008 SHALL have port load_val, input, 3, the preset value.
REQ-009 SHALL have port x, output, 3, the registered select feeding the downstream 3-to-8 decoder input.
REQ-010 SHALL have port en, output, 1, the registered decoder enable.
REQ-011 SHALL have port busy, output, 1, high while in RUN.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse at completion of a single sweep.
REQ-013 SHALL have port wrap, output, 1, a one-cycle pulse when x steps 7->0 (up) or 0->7 (down).

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 and stop=0 SHALL move the FSM to RUN on the next edge, latch mode, clear the prescaler and step count, and assert en; x keeps its current value as the first code.
REQ-016 In IDLE, start and stop asserted together SHALL leave the FSM in IDLE (stop wins).
REQ-017 In IDLE, load=1 SHALL set x<=load_val on the next edge; if start is asserted in the same cycle, the loaded value is the first code.
REQ-018 While in RUN or DONE, load and start SHALL be ignored.
REQ-019 In RUN, the prescaler SHALL count 0..DIV-1; on the cycle it equals DIV-1 it wraps to 0 and x steps +1 mod 8 (up) or -1 mod 8 (down) on that edge; each code is therefore held exactly DIV cycles.
REQ-020 Single sweep SHALL present exactly 8 codes. On the 8th step edge it SHALL go to DONE with en=0, x restored to its start value (the natural mod-8 result), and done=1 for exactly that one cycle; DONE always returns to IDLE on the next edge.
REQ-021 Continuous mode SHALL never end by itself; busy and en stay high until stop.
REQ-022 stop=1 in RUN SHALL go to IDLE on the next edge with en=0, x frozen at its current value, no done pulse, and no step on that edge, even if the prescaler is at DIV-1.
REQ-023 wrap SHALL pulse on the cycle after the wrapping step edge, including on the final step of a sweep.
REQ-024 With DIV=1, x SHALL step every cycle in RUN.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, x=0, en=0, busy=0, done=0, wrap=0, prescaler=0, step count=0, and latched mode=00, including mid-sequence.
REQ-026 After rst deasserts, the first accepted start SHALL behave as from power-up.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the mode encodings (MODE_UP_ONCE, MODE_DN_ONCE, MODE_UP_CONT, MODE_DN_CONT) and the select width constant 3.
REQ-028 The prescaler SHALL be a sub-module tick_gen (parameter DIV, inputs clk/rst/clear/run, output tick) asserting tick one cycle per DIV counted cycles.
REQ-029 The step count SHALL be 4 bits wide; x arithmetic SHALL be 3-bit modulo with no overflow flag.

Verification
REQ-030 DIV=4, load 3'b101, start with mode=00: x shows 5,6,7,0,1,2,3,4, each held 4 cycles; wrap pulses once after 7->0; then done pulses once, en=0, x=5.
REQ-031 DIV=2, x=0, mode=11: x shows 0,7,6,5..., wrap after 0->7; stop asserted while x=6 with the prescaler at DIV-1 -> idle next edge, x=6, en=0, no done.
REQ-032 Start and stop in the same IDLE cycle -> busy stays 0; start alone during RUN, or load during RUN -> x sequence unchanged.
REQ-033 rst asserted asynchronously between clock edges while x=3 in RUN -> outputs are 0 before the next clk edge.
REQ-034 DIV=1, mode=10 from x=0: x steps every cycle 0..7,0; wrap every 8th cycle; en continuous.
REQ-035 Connect a 3-to-8 decoder model and check one-hot f equals 1<<x whenever en=1 and f=0 otherwise, across all of the scenarios above.

Source files
------------

// File: rtl/sel_sequencer_pkg.sv
// Shared definitions for the select sequencer.
//
// Contents:
//   SelWidth / StepWidth - width of the select output and of the sweep step counter
//   state_e              - sequencer FSM state encoding
//   mode_e               - sequencing modes, latched when a start is accepted
//   mode_is_down/cont    - decode helpers for mode_e
//   sel_step/sel_wraps   - 3-bit modulo select arithmetic and wrap detection
package sel_sequencer_pkg;

  localparam int unsigned SelWidth  = 3;
  localparam int unsigned StepWidth = 4;

  // Number of step edges in a single sweep, minus one: the 8th step ends it.
  localparam logic [StepWidth-1:0] LastStep = 4'd7;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Bit 0 selects direction (1 = down), bit 1 selects continuous operation.
  typedef enum logic [1:0] {
    MODE_UP_ONCE = 2'b00,
    MODE_DN_ONCE = 2'b01,
    MODE_UP_CONT = 2'b10,
    MODE_DN_CONT = 2'b11
  } mode_e;

  function automatic logic mode_is_down(input mode_e m);
    return (m == MODE_DN_ONCE) || (m == MODE_DN_CONT);
  endfunction

  function automatic logic mode_is_cont(input mode_e m);
    return (m == MODE_UP_CONT) || (m == MODE_DN_CONT);
  endfunction

  // Next select code; the 3-bit result wraps naturally, no overflow flag.
  function automatic logic [SelWidth-1:0] sel_step(input logic [SelWidth-1:0] cur,
                                                    input logic              down);
    return down ? (cur - 3'd1) : (cur + 3'd1);
  endfunction

  // True when stepping from cur crosses the 7/0 boundary in the given direction.
  function automatic logic sel_wraps(input logic [SelWidth-1:0] cur, input logic down);
    return down ? (cur == 3'd0) : (cur == 3'd7);
  endfunction

endpackage

// File: rtl/sel_sequencer_tick_gen.sv
// Prescaler for the select sequencer.
//
// Counts 0..DIV-1 while run is high and asserts tick on the cycle the count
// equals DIV-1, wrapping the count back to 0 on that edge. This yields one
// tick per DIV counted cycles. clear has priority and holds the count at 0.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   clear - synchronous clear of the count
//   run   - count enable
//   tick  - high for the last cycle of each DIV-cycle period
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  // DIV is limited to 1..255 so an 8-bit count always suffices.
  localparam logic [7:0] CntLast = 8'(DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Tick is gated by run so a cycle where counting is suppressed never steps.
  assign tick = run && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? 8'd0 : (cnt_q + 8'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sel_sequencer.sv
// Select sequencer driving a downstream 3-to-8 decoder.
//
// From IDLE an accepted start begins stepping the select x up or down, each
// code held for DIV cycles. Single-sweep modes present 8 codes and return x to
// its starting value, pulsing done; continuous modes run until stop.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - begin a sequence (IDLE only; stop in the same cycle wins)
//   stop     - abort a running sequence, x frozen
//   mode     - mode_e encoding, latched on an accepted start
//   load     - preset x from load_val (IDLE only)
//   load_val - preset value
//   x        - registered select code
//   en       - registered decoder enable, high while stepping
//   busy     - high while in RUN
//   done     - one-cycle pulse when a single sweep completes
//   wrap     - one-cycle pulse the cycle after x crosses 7->0 or 0->7
module sel_sequencer
  import sel_sequencer_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic                load,
  input  logic [SelWidth-1:0] load_val,
  output logic [SelWidth-1:0] x,
  output logic                en,
  output logic                busy,
  output logic                done,
  output logic                wrap
);

  state_e                 state_q;
  mode_e                  mode_q;
  logic [StepWidth-1:0]   step_cnt_q;
  logic [SelWidth-1:0]    x_q;
  logic                   en_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   wrap_q;

  logic                   presc_clear;
  logic                   presc_run;
  logic                   tick;
  logic                   down;

  // The prescaler is held at 0 outside RUN, so every accepted start begins a
  // fresh dwell. A stop suppresses counting so no step can land on its edge.
  assign presc_clear = (state_q != StRun);
  assign presc_run   = (state_q == StRun) && !stop;
  assign down        = mode_is_down(mode_q);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .run   (presc_run),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= MODE_UP_ONCE;
      step_cnt_q <= '0;
      x_q        <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      // Pulse outputs default low each cycle.
      done_q <= 1'b0;
      wrap_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          // A load in the same cycle as start provides the first code.
          if (load) begin
            x_q <= load_val;
          end
          if (start && !stop) begin
            state_q    <= StRun;
            mode_q     <= mode_e'(mode);
            step_cnt_q <= '0;
            en_q       <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        StRun: begin
          if (stop) begin
            state_q <= StIdle;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tick) begin
            x_q        <= sel_step(x_q, down);
            step_cnt_q <= step_cnt_q + 4'd1;
            wrap_q     <= sel_wraps(x_q, down);
            // The 8th step of a single sweep lands x back on its start value.
            if (!mode_is_cont(mode_q) && (step_cnt_q == LastStep)) begin
              state_q <= StDone;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x    = x_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// Directed bench for sel_sequencer. Three instances share the inputs:
// u_a (DIV=4), u_b (DIV=2), u_c (DIV=1). Each is followed by a 3-to-8
// decoder model whose one-hot output is checked along with the DUT outputs.
module tb_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] x_a, x_b, x_c;
  logic       en_a, en_b, en_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic [7:0] f_a, f_b, f_c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sel_sequencer #(.DIV(4)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load(load),
    .load_val(load_val), .x(x_a), .en(en_a), .busy(busy_a), .done(done_a), .wrap(wrap_a)
  );
  sel_sequencer #(.DIV(2)) u_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load(load),
    .load_val(load_val), .x(x_b), .en(en_b), .busy(busy_b), .done(done_b), .wrap(wrap_b)
  );
  sel_sequencer #(.DIV(1)) u_c (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load(load),
    .load_val(load_val), .x(x_c), .en(en_c), .busy(busy_c), .done(done_c), .wrap(wrap_c)
  );

  // Downstream 3-to-8 decoder models.
  assign f_a = en_a ? (8'd1 << x_a) : 8'd0;
  assign f_b = en_b ? (8'd1 << x_b) : 8'd0;
  assign f_c = en_c ? (8'd1 << x_c) : 8'd0;

  // Observed bundle: {x, en, busy, done, wrap, f}.
  wire [14:0] obs_a = {x_a, en_a, busy_a, done_a, wrap_a, f_a};
  wire [14:0] obs_b = {x_b, en_b, busy_b, done_b, wrap_b, f_b};
  wire [14:0] obs_c = {x_c, en_c, busy_c, done_c, wrap_c, f_c};

  // Expected bundle built from expected fields; f is one-hot of x only when enabled.
  function automatic logic [14:0] model_vec(input logic [2:0] ex, input logic een,
                                            input logic ebusy, input logic edone,
                                            input logic ewrap);
    logic [7:0] ef;
    ef = een ? (8'd1 << ex) : 8'd0;
    return {ex, een, ebusy, edone, ewrap, ef};
  endfunction

  task automatic tick_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    start = 1'b0; stop = 1'b0; load = 1'b0; mode = 2'b00; load_val = 3'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [14:0] ev;
    #1 rst = 1'b1;
    #1;
    ev = model_vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_a !== ev) begin bad++; $display("FAIL reset_a: got %h want %h", obs_a, ev); end
    total++;
    if (obs_b !== ev) begin bad++; $display("FAIL reset_b: got %h want %h", obs_b, ev); end
    total++;
    if (obs_c !== ev) begin bad++; $display("FAIL reset_c: got %h want %h", obs_c, ev); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // DIV=4, load 5, single sweep up.
  task automatic test_sweep_up;
    logic [14:0] ev;
    do_reset();
    load = 1'b1; load_val = 3'd5; mode = 2'b00; start = 1'b1;
    tick_clk();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      // Code k = i/4; 7->0 is the 3rd step, so wrap shows on the first cycle of code 3.
      ev = model_vec(3'(5 + i / 4), 1'b1, 1'b1, 1'b0, i == 12);
      total++;
      if (obs_a !== ev) begin bad++; $display("FAIL sweep_up cyc %0d: got %h want %h", i, obs_a, ev); end
      tick_clk();
    end
    ev = model_vec(3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs_a !== ev) begin bad++; $display("FAIL sweep_up done: got %h want %h", obs_a, ev); end
    tick_clk();
    ev = model_vec(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_a !== ev) begin bad++; $display("FAIL sweep_up after: got %h want %h", obs_a, ev); end
  endtask

  // DIV=2, continuous down from 0, stop while x=6 and prescaler at DIV-1.
  task automatic test_down_stop;
    logic [14:0] ev;
    do_reset();
    mode = 2'b11; start = 1'b1;
    tick_clk();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ev = model_vec(3'(0 - i / 2), 1'b1, 1'b1, 1'b0, i == 2);
      total++;
      if (obs_b !== ev) begin bad++; $display("FAIL down cyc %0d: got %h want %h", i, obs_b, ev); end
      if (i < 5) tick_clk();
    end
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
    ev = model_vec(3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_b !== ev) begin bad++; $display("FAIL down stop: got %h want %h", obs_b, ev); end
    repeat (3) tick_clk();
    total++;
    if (obs_b !== ev) begin bad++; $display("FAIL down frozen: got %h want %h", obs_b, ev); end
  endtask

  task automatic test_start_stop_idle;
    logic [14:0] ev;
    do_reset();
    start = 1'b1; stop = 1'b1;
    tick_clk();
    ev = model_vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_a !== ev) begin bad++; $display("FAIL start_stop 1: got %h want %h", obs_a, ev); end
    tick_clk();
    total++;
    if (obs_a !== ev) begin bad++; $display("FAIL start_stop 2: got %h want %h", obs_a, ev); end
    start = 1'b0; stop = 1'b0;
  endtask

  // DIV=4 continuous up from 2; start/load/mode toggled during RUN must not disturb x.
  task automatic test_ignore_in_run;
    logic [14:0] ev;
    do_reset();
    load = 1'b1; load_val = 3'd2; mode = 2'b10; start = 1'b1;
    tick_clk();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin start = 1'b1; load = 1'b1; load_val = 3'd7; mode = 2'b01; end
      if (i == 9) begin start = 1'b0; load = 1'b0; end
      ev = model_vec(3'(2 + i / 4), 1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if (obs_a !== ev) begin bad++; $display("FAIL ignore cyc %0d: got %h want %h", i, obs_a, ev); end
      tick_clk();
    end
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
    ev = model_vec(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_a !== ev) begin bad++; $display("FAIL ignore stop: got %h want %h", obs_a, ev); end
  endtask

  // Async reset mid-run at x=3, then a fresh single sweep from x=0.
  task automatic test_async_reset;
    logic [14:0] ev;
    do_reset();
    load = 1'b1; load_val = 3'd3; mode = 2'b10; start = 1'b1;
    tick_clk();
    load = 1'b0; start = 1'b0;
    repeat (2) tick_clk();
    ev = model_vec(3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs_a !== ev) begin bad++; $display("FAIL arst pre: got %h want %h", obs_a, ev); end
    #3 rst = 1'b1;
    #1;
    ev = model_vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_a !== ev) begin bad++; $display("FAIL arst a: got %h want %h", obs_a, ev); end
    total++;
    if (obs_b !== ev) begin bad++; $display("FAIL arst b: got %h want %h", obs_b, ev); end
    total++;
    if (obs_c !== ev) begin bad++; $display("FAIL arst c: got %h want %h", obs_c, ev); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mode = 2'b00; start = 1'b1;
    tick_clk();
    start = 1'b0;
    ev = model_vec(3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs_a !== ev) begin bad++; $display("FAIL arst restart: got %h want %h", obs_a, ev); end
    repeat (4) tick_clk();
    ev = model_vec(3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs_a !== ev) begin bad++; $display("FAIL arst step: got %h want %h", obs_a, ev); end
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
  endtask

  // DIV=1 continuous up from 0: step every cycle, wrap every 8th; stop blocks the step.
  task automatic test_div1;
    logic [14:0] ev;
    do_reset();
    mode = 2'b10; start = 1'b1;
    tick_clk();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ev = model_vec(3'(i), 1'b1, 1'b1, 1'b0, (i == 8) || (i == 16));
      total++;
      if (obs_c !== ev) begin bad++; $display("FAIL div1 cyc %0d: got %h want %h", i, obs_c, ev); end
      tick_clk();
    end
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
    ev = model_vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_c !== ev) begin bad++; $display("FAIL div1 stop: got %h want %h", obs_c, ev); end
  endtask

  initial begin
    test_reset();
    test_sweep_up();
    test_down_stop();
    test_start_stop_idle();
    test_ignore_in_run();
    test_async_reset();
    test_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
